// File: rtl/dong_ho_pkg.sv
// Shared types and constants for the clock / time-set controller.
// Holds the FSM state enum, BCD limits, display blank bit positions and
// two small helpers (next set-mode state, blank mask for a state/phase).
package dong_ho_pkg;

   localparam int unsigned BCD_W   = 8;
   localparam int unsigned BLANK_W = 6;

   localparam logic [BCD_W-1:0] BCD_ZERO   = 8'h00;
   localparam logic [BCD_W-1:0] GIO_MAX_24 = 8'h23;
   localparam logic [BCD_W-1:0] MS_MAX     = 8'h59;

   // Blank bit positions, left-most display digit is bit 5
   localparam int unsigned BLANK_GIO_CHUC  = 5;
   localparam int unsigned BLANK_GIO_DV    = 4;
   localparam int unsigned BLANK_PHUT_CHUC = 3;
   localparam int unsigned BLANK_PHUT_DV   = 2;
   localparam int unsigned BLANK_GIAY_CHUC = 1;
   localparam int unsigned BLANK_GIAY_DV   = 0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_GIO  = 2'd1,
      SET_PHUT = 2'd2,
      SET_GIAY = 2'd3
   } trang_thai_t;

   // Mode-button sequence: RUN -> SET_GIO -> SET_PHUT -> SET_GIAY -> RUN
   function automatic trang_thai_t trang_thai_ke(input trang_thai_t s);
      trang_thai_t k;
      k = RUN;
      case (s)
         RUN:      k = SET_GIO;
         SET_GIO:  k = SET_PHUT;
         SET_PHUT: k = SET_GIAY;
         SET_GIAY: k = RUN;
         default:  k = RUN;
      endcase
      return k;
   endfunction

   // Digit pair of the field being edited is blanked only in the "off" phase
   function automatic logic [BLANK_W-1:0] mat_na_blank(input trang_thai_t s,
                                                       input logic        pha);
      logic [BLANK_W-1:0] m;
      m = '0;
      if (pha) begin
         case (s)
            SET_GIO: begin
               m[BLANK_GIO_CHUC] = 1'b1;
               m[BLANK_GIO_DV]   = 1'b1;
            end
            SET_PHUT: begin
               m[BLANK_PHUT_CHUC] = 1'b1;
               m[BLANK_PHUT_DV]   = 1'b1;
            end
            SET_GIAY: begin
               m[BLANK_GIAY_CHUC] = 1'b1;
               m[BLANK_GIAY_DV]   = 1'b1;
            end
            default: m = '0;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/dong_ho_bcd_dem2.sv
// Two-digit BCD counter with programmable wrap value.
// Ports: clk, rst (sync, active-high), inc (count enable), max (BCD wrap
// value), val (registered BCD count), carry_out (combinational: inc while
// val == max, i.e. this increment wraps to 00).
module bcd_dem2
   import dong_ho_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic [BCD_W-1:0] max,
   output logic [BCD_W-1:0] val,
   output logic             carry_out
);

   assign carry_out = inc && (val == max);

   // Wrap at max, otherwise units 9 rolls into the tens digit
   always_ff @(posedge clk) begin
      if (rst) begin
         val <= BCD_ZERO;
      end else if (inc) begin
         if (val == max) begin
            val <= BCD_ZERO;
         end else if (val[3:0] == 4'd9) begin
            val <= {val[7:4] + 4'd1, 4'd0};
         end else begin
            val <= {val[7:4], val[3:0] + 4'd1};
         end
      end
   end

endmodule

// File: rtl/dieu_khien_dong_ho.sv
// Timekeeping and time-set controller for the six-digit clock display.
// Ports: clk, rst (sync, active-high), tick_1hz (1 s strobe), tick_blink
// (blink half-period strobe), btn_mode / btn_inc (debounced pulses),
// gio / phut / giay (BCD time), blank (per-digit blank, [5] = hour tens),
// set_active (high outside RUN). All outputs registered.
module dieu_khien_dong_ho
   import dong_ho_pkg::*;
#(
   parameter logic [BCD_W-1:0] GIO_MAX  = GIO_MAX_24,
   parameter logic [BCD_W-1:0] PHUT_MAX = MS_MAX,
   parameter logic [BCD_W-1:0] GIAY_MAX = MS_MAX
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               tick_1hz,
   input  logic               tick_blink,
   input  logic               btn_mode,
   input  logic               btn_inc,
   output logic [BCD_W-1:0]   gio,
   output logic [BCD_W-1:0]   phut,
   output logic [BCD_W-1:0]   giay,
   output logic [BLANK_W-1:0] blank,
   output logic               set_active
);

   trang_thai_t trang_thai;
   logic        pha_blink;

   logic tick_chay;
   logic tang_sua;
   logic inc_gio, inc_phut, inc_giay;
   logic carry_gio, carry_phut, carry_giay;

   // Ticks only count in RUN; edits are dropped when mode is pressed too
   assign tick_chay = (trang_thai == RUN) && tick_1hz;
   assign tang_sua  = btn_inc && !btn_mode;

   assign inc_giay = tick_chay ||
                     ((trang_thai == SET_GIAY) && tang_sua);
   assign inc_phut = (tick_chay && carry_giay) ||
                     ((trang_thai == SET_PHUT) && tang_sua);
   assign inc_gio  = (tick_chay && carry_giay && carry_phut) ||
                     ((trang_thai == SET_GIO) && tang_sua);

   bcd_dem2 u_giay (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_giay),
      .max       (GIAY_MAX),
      .val       (giay),
      .carry_out (carry_giay)
   );

   bcd_dem2 u_phut (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_phut),
      .max       (PHUT_MAX),
      .val       (phut),
      .carry_out (carry_phut)
   );

   // Hour carry is unused: midnight simply wraps
   bcd_dem2 u_gio (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_gio),
      .max       (GIO_MAX),
      .val       (gio),
      .carry_out (carry_gio)
   );

   logic khong_dung;
   assign khong_dung = carry_gio;

   // Set-mode FSM, blink phase and registered blank/set_active.
   // blank and set_active are computed from the values being loaded so
   // they always match the state/phase registers of the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         trang_thai <= RUN;
         pha_blink  <= 1'b0;
         blank      <= '0;
         set_active <= 1'b0;
      end else if (btn_mode) begin
         trang_thai <= trang_thai_ke(trang_thai);
         set_active <= (trang_thai_ke(trang_thai) != RUN);
         blank      <= '0;
         if (trang_thai_ke(trang_thai) != RUN) begin
            // New field shows immediately on entry
            pha_blink <= 1'b0;
         end else begin
            pha_blink <= pha_blink ^ tick_blink;
         end
      end else begin
         pha_blink  <= pha_blink ^ tick_blink;
         set_active <= (trang_thai != RUN);
         blank      <= mat_na_blank(trang_thai, pha_blink ^ tick_blink);
      end
   end

endmodule

// File: tb/tb_dieu_khien_dong_ho.sv
// Self-checking bench for dieu_khien_dong_ho: directed scenarios plus
// random stimulus, compared every cycle against an integer-time model.
module tb_dieu_khien_dong_ho;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       tick_blink = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [7:0] gio, phut, giay;
   logic [5:0] blank;
   logic       set_active;

   int unsigned n_check = 0;
   int unsigned n_err   = 0;

   // Reference model: plain integers, state 0=RUN 1=hour 2=min 3=sec
   int m_h = 0, m_m = 0, m_s = 0, m_st = 0;
   bit m_ph = 1'b0;

   always #5 clk = ~clk;

   dieu_khien_dong_ho dut (
      .clk        (clk),
      .rst        (rst),
      .tick_1hz   (tick_1hz),
      .tick_blink (tick_blink),
      .btn_mode   (btn_mode),
      .btn_inc    (btn_inc),
      .gio        (gio),
      .phut       (phut),
      .giay       (giay),
      .blank      (blank),
      .set_active (set_active)
   );

   task automatic kiem_tra(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_check++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   function automatic logic [5:0] blank_mong_doi();
      if (m_st != 0 && m_ph) return 6'(3 << (2 * (3 - m_st)));
      return 6'd0;
   endfunction

   task automatic mo_hinh(input bit r, input bit t, input bit b,
                          input bit md, input bit bi);
      if (r) begin
         m_h = 0; m_m = 0; m_s = 0; m_st = 0; m_ph = 1'b0;
      end else begin
         if (m_st == 0 && t) begin
            m_s++;
            if (m_s == 60) begin
               m_s = 0; m_m++;
               if (m_m == 60) begin
                  m_m = 0; m_h = (m_h + 1) % 24;
               end
            end
         end
         if (!md && bi) begin
            case (m_st)
               1: m_h = (m_h + 1) % 24;
               2: m_m = (m_m + 1) % 60;
               3: m_s = (m_s + 1) % 60;
               default: ;
            endcase
         end
         if (md) begin
            m_st = (m_st + 1) % 4;
            m_ph = (m_st != 0) ? 1'b0 : (m_ph ^ b);
         end else begin
            m_ph = m_ph ^ b;
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model, check all outputs
   task automatic chu_ky(input bit r, input bit t, input bit b,
                         input bit md, input bit bi);
      rst = r; tick_1hz = t; tick_blink = b; btn_mode = md; btn_inc = bi;
      @(posedge clk);
      mo_hinh(r, t, b, md, bi);
      #1;
      rst = 0; tick_1hz = 0; tick_blink = 0; btn_mode = 0; btn_inc = 0;
      kiem_tra("gio", 32'(gio), 32'(bcd(m_h)));
      kiem_tra("phut", 32'(phut), 32'(bcd(m_m)));
      kiem_tra("giay", 32'(giay), 32'(bcd(m_s)));
      kiem_tra("blank", 32'(blank), 32'(blank_mong_doi()));
      kiem_tra("set_active", 32'(set_active), 32'(m_st != 0));
   endtask

   // Reset, then dial in a time through the set modes, ending in RUN
   task automatic dat_gio(input int h, input int m, input int s);
      chu_ky(1, 0, 0, 0, 0);
      chu_ky(0, 0, 0, 1, 0);
      for (int i = 0; i < h; i++) chu_ky(0, 0, 0, 0, 1);
      chu_ky(0, 0, 0, 1, 0);
      for (int i = 0; i < m; i++) chu_ky(0, 0, 0, 0, 1);
      chu_ky(0, 0, 0, 1, 0);
      for (int i = 0; i < s; i++) chu_ky(0, 0, 0, 0, 1);
      chu_ky(0, 0, 0, 1, 0);
   endtask

   initial begin
      // Reset state
      chu_ky(1, 0, 0, 0, 0);
      kiem_tra("rst_gio", 32'(gio), 32'h00);
      kiem_tra("rst_blank", 32'(blank), 32'h00);
      kiem_tra("rst_set_active", 32'(set_active), 32'h0);

      // 60 seconds -> 00:01:00
      for (int i = 0; i < 60; i++) chu_ky(0, 1, 0, 0, 0);
      kiem_tra("60s_giay", 32'(giay), 32'h00);
      kiem_tra("60s_phut", 32'(phut), 32'h01);

      // Midnight rollover
      dat_gio(23, 59, 59);
      kiem_tra("pre_wrap_gio", 32'(gio), 32'h23);
      chu_ky(0, 1, 0, 0, 0);
      kiem_tra("wrap_gio", 32'(gio), 32'h00);
      kiem_tra("wrap_phut", 32'(phut), 32'h00);
      kiem_tra("wrap_giay", 32'(giay), 32'h00);

      // Hour edit from 10:20:30, tick ignored while editing
      dat_gio(10, 20, 30);
      chu_ky(0, 0, 0, 1, 0);
      chu_ky(0, 1, 0, 0, 0);
      kiem_tra("frozen_giay", 32'(giay), 32'h30);
      for (int i = 0; i < 3; i++) chu_ky(0, 0, 0, 0, 1);
      kiem_tra("edit_gio", 32'(gio), 32'h13);
      kiem_tra("edit_phut", 32'(phut), 32'h20);
      kiem_tra("edit_active", 32'(set_active), 32'h1);

      // Hour wrap in SET_GIO, minute wrap in SET_PHUT without carry
      dat_gio(22, 59, 0);
      chu_ky(0, 0, 0, 1, 0);
      chu_ky(0, 0, 0, 0, 1);
      kiem_tra("set_gio_23", 32'(gio), 32'h23);
      chu_ky(0, 0, 0, 0, 1);
      kiem_tra("set_gio_00", 32'(gio), 32'h00);
      chu_ky(0, 0, 0, 1, 0);
      chu_ky(0, 0, 0, 0, 1);
      kiem_tra("set_phut_00", 32'(phut), 32'h00);
      kiem_tra("set_phut_gio", 32'(gio), 32'h00);

      // Blink in SET_PHUT
      chu_ky(0, 0, 1, 0, 0);
      kiem_tra("blink_on", 32'(blank), 32'h0C);
      chu_ky(0, 0, 1, 0, 0);
      kiem_tra("blink_off", 32'(blank), 32'h00);

      // SET_GIAY: mode + tick returns to RUN, tick discarded
      chu_ky(0, 0, 0, 1, 0);
      chu_ky(0, 1, 0, 1, 0);
      kiem_tra("back_run_giay", 32'(giay), 32'h00);
      kiem_tra("back_run_active", 32'(set_active), 32'h0);
      chu_ky(0, 1, 0, 0, 0);
      kiem_tra("resume_giay", 32'(giay), 32'h01);

      // No blanking in RUN
      for (int i = 0; i < 4; i++) begin
         chu_ky(0, 0, 1, 0, 0);
         kiem_tra("run_blank", 32'(blank), 32'h00);
      end

      // Mode + inc in SET_GIO: mode wins
      chu_ky(0, 0, 0, 1, 0);
      chu_ky(0, 0, 0, 1, 1);
      kiem_tra("mode_inc_gio", 32'(gio), 32'h00);
      kiem_tra("mode_inc_active", 32'(set_active), 32'h1);

      // Reset mid-edit
      dat_gio(5, 17, 9);
      chu_ky(0, 0, 0, 1, 0);
      chu_ky(0, 0, 1, 1, 0);
      chu_ky(0, 0, 1, 0, 0);
      chu_ky(1, 1, 1, 1, 1);
      kiem_tra("mid_rst_gio", 32'(gio), 32'h00);
      kiem_tra("mid_rst_phut", 32'(phut), 32'h00);
      kiem_tra("mid_rst_giay", 32'(giay), 32'h00);
      kiem_tra("mid_rst_blank", 32'(blank), 32'h00);
      kiem_tra("mid_rst_active", 32'(set_active), 32'h0);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         chu_ky($urandom_range(0, 299) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 11) == 0,
                $urandom_range(0, 2) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_check, n_err);
      $finish;
   end

endmodule

// File: doc/dieu_khien_dong_ho.md
Name: dieu_khien_dong_ho

Overview:
- Timekeeping and time-set controller that drives the BCD hour/minute/second fields consumed by the six-digit 7-segment display stage.
- Advances HH:MM:SS on a 1 Hz strobe.
- Runs a button-driven set-mode FSM that selects one field at a time for increment.
- Produces a per-digit blank mask so the field being edited blinks on the display.

Parameters:
- GIO_MAX, 8'h23, BCD maximum hour value; hour wraps from this to 8'h00.
- PHUT_MAX, 8'h59, BCD maximum minute value.
- GIAY_MAX, 8'h59, BCD maximum second value.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tick_1hz  input  1  one-cycle strobe, once per second.
- tick_blink  input  1  one-cycle strobe at the blink half-period (2 Hz).
- btn_mode  input  1  debounced one-cycle pulse; advances the set-mode FSM.
- btn_inc  input  1  debounced one-cycle pulse; increments the selected field.
- gio  output  8  hours, BCD ([7:4] tens, [3:0] units).
- phut  output  8  minutes, BCD.
- giay  output  8  seconds, BCD.
- blank  output  6  active-high digit blank; bit order is [5] hour tens, [4] hour units, [3] minute tens, [2] minute units, [1] second tens, [0] second units.
- set_active  output  1  high whenever the FSM is not in RUN.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst) and takes priority over every other input.
- Reset values:
  - gio = phut = giay = 8'h00.
  - FSM state = RUN; blink_phase = 0.
  - blank = 6'b000000; set_active = 0.
- All outputs are registered. Any update caused by an input strobe in cycle N is visible in cycle N+1.
- FSM states: RUN, SET_GIO, SET_PHUT, SET_GIAY.
  - btn_mode advances RUN -> SET_GIO -> SET_PHUT -> SET_GIAY -> RUN.
  - The FSM does not change without btn_mode.
- RUN state:
  - tick_1hz increments giay.
  - At giay == GIAY_MAX: giay -> 00 and phut increments.
  - At phut == PHUT_MAX with a carry in: phut -> 00 and gio increments.
  - At gio == GIO_MAX with a carry in: gio -> 00.
  - Example: 23:59:59 + tick -> 00:00:00 in one cycle.
  - btn_inc is ignored.
- SET_x states:
  - tick_1hz is ignored; time is frozen and no tick is buffered.
  - btn_inc increments only the selected field, with wrap at its MAX.
  - No carry propagates into any other field.
- BCD arithmetic:
  - Units 9 -> 0 with tens+1.
  - A field equal to its MAX wraps to 00.
  - Outputs only ever hold legal BCD values in 00..MAX.
- Simultaneous events:
  - btn_mode and btn_inc in the same cycle: btn_mode wins and btn_inc is dropped.
  - btn_mode and tick_1hz in RUN: the tick is applied and the FSM moves to SET_GIO.
  - btn_mode and tick_1hz in SET_GIAY: the FSM returns to RUN and the tick is discarded. Counting resumes on the next tick_1hz.
- Blink:
  - blink_phase toggles on every tick_blink, in every state.
  - blank[pair] = 1 only when in the SET state for that field AND blink_phase == 1; otherwise blank = 0.
  - On entering a new SET state, blink_phase is forced to 0 so the field is shown immediately.
- set_active = (state != RUN).
- Reset mid-edit: returns to RUN with the time cleared to 00:00:00.

Decomposition:
- Shared package dong_ho_pkg holds:
  - the state enum (RUN, SET_GIO, SET_PHUT, SET_GIAY);
  - BCD constants BCD_ZERO = 8'h00, GIO_MAX_24 = 8'h23, MS_MAX = 8'h59;
  - blank bit-index constants.
- One sub-module, bcd_dem2: a 2-digit BCD counter.
  - Inputs: clk, rst, inc, max.
  - Outputs: val, carry_out (asserted combinationally when inc && val == max).
  - Instantiated three times, with the inc inputs gated by the FSM.

Test Plan:
- Reset, then 60 tick_1hz -> giay 8'h00 and phut 8'h01. Continue to 23:59:59 plus one tick -> gio/phut/giay = 00/00/00 and no overflow.
- From 10:20:30: btn_mode, then 3x btn_inc -> gio 8'h13, phut 8'h20, set_active = 1. tick_1hz during this leaves giay at 8'h30.
- SET_GIO at 8'h22: 2x btn_inc -> 8'h23 then 8'h00. SET_PHUT at 8'h59: btn_inc -> 8'h00 with gio unchanged.
- In SET_PHUT: tick_blink pulses -> blank alternates 6'b000000 and 6'b001100. In RUN: blank stays 6'b000000 regardless of tick_blink.
- btn_mode and btn_inc in the same cycle in SET_GIO -> state becomes SET_PHUT and gio is unchanged. btn_mode in SET_GIAY -> RUN, and the next tick_1hz increments giay.
- rst asserted mid-edit in SET_PHUT at 05:17:09 -> next cycle shows 00:00:00, RUN, blank 0, set_active 0.
